// File: rtl/jtag_pkg.sv
// Shared TAP types and constants: state encodings, opcodes and IR capture pattern.
package jtag_pkg;

   localparam int IR_W = 4;
   localparam logic [IR_W-1:0] IR_CAPTURE = 4'b0101;

   localparam logic [IR_W-1:0] OP_IDCODE   = 4'h1;
   localparam logic [IR_W-1:0] OP_USERDATA = 4'h2;
   localparam logic [IR_W-1:0] OP_BYPASS   = 4'hF;

   typedef enum logic [3:0] {
      ST_TLR      = 4'h0,
      ST_RTI      = 4'h1,
      ST_SEL_DR   = 4'h2,
      ST_CAP_DR   = 4'h3,
      ST_SHIFT_DR = 4'h4,
      ST_EXIT1_DR = 4'h5,
      ST_PAUSE_DR = 4'h6,
      ST_EXIT2_DR = 4'h7,
      ST_UPD_DR   = 4'h8,
      ST_SEL_IR   = 4'h9,
      ST_CAP_IR   = 4'hA,
      ST_SHIFT_IR = 4'hB,
      ST_EXIT1_IR = 4'hC,
      ST_PAUSE_IR = 4'hD,
      ST_EXIT2_IR = 4'hE,
      ST_UPD_IR   = 4'hF
   } tap_state_t;

   typedef enum logic [1:0] {
      DR_BYPASS = 2'd0,
      DR_IDCODE = 2'd1,
      DR_USER   = 2'd2
   } dr_sel_t;

   // Any opcode we do not implement falls back to the 1-bit bypass register.
   function automatic dr_sel_t decode_ir(input logic [IR_W-1:0] ir);
      dr_sel_t sel;
      case (ir)
         OP_IDCODE:   sel = DR_IDCODE;
         OP_USERDATA: sel = DR_USER;
         default:     sel = DR_BYPASS;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller; next state depends only on current state and TMS.
//
// state       | meaning
// ST_TLR      | test-logic-reset, IR held at IDCODE
// ST_RTI      | run-test/idle
// ST_SEL_DR   | select DR scan
// ST_CAP_DR   | capture parallel value into selected DR
// ST_SHIFT_DR | shift selected DR toward TDO
// ST_EXIT1_DR | leave shift, choose pause or update
// ST_PAUSE_DR | DR scan suspended
// ST_EXIT2_DR | resume shift or go to update
// ST_UPD_DR   | commit DR (USERDATA writes core)
// ST_SEL_IR   | select IR scan
// ST_CAP_IR   | load IR capture pattern
// ST_SHIFT_IR | shift IR shift register
// ST_EXIT1_IR | leave shift, choose pause or update
// ST_PAUSE_IR | IR scan suspended
// ST_EXIT2_IR | resume shift or go to update
// ST_UPD_IR   | commit new instruction
module jtag_tap_fsm
   import jtag_pkg::*;
(
   input  logic clk_sys,
   input  logic rst,
   input  logic tms,
   output logic capture_dr,
   output logic shift_dr,
   output logic update_dr,
   output logic capture_ir,
   output logic shift_ir,
   output logic update_ir,
   output logic tlr
);

   tap_state_t state_q;
   tap_state_t state_d;

   always_ff @(posedge clk_sys) begin
      if (rst) state_q <= ST_TLR;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_TLR:      state_d = tms ? ST_TLR      : ST_RTI;
         ST_RTI:      state_d = tms ? ST_SEL_DR   : ST_RTI;
         ST_SEL_DR:   state_d = tms ? ST_SEL_IR   : ST_CAP_DR;
         ST_CAP_DR:   state_d = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
         ST_SHIFT_DR: state_d = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
         ST_EXIT1_DR: state_d = tms ? ST_UPD_DR   : ST_PAUSE_DR;
         ST_PAUSE_DR: state_d = tms ? ST_EXIT2_DR : ST_PAUSE_DR;
         ST_EXIT2_DR: state_d = tms ? ST_UPD_DR   : ST_SHIFT_DR;
         ST_UPD_DR:   state_d = tms ? ST_SEL_DR   : ST_RTI;
         ST_SEL_IR:   state_d = tms ? ST_TLR      : ST_CAP_IR;
         ST_CAP_IR:   state_d = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
         ST_SHIFT_IR: state_d = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
         ST_EXIT1_IR: state_d = tms ? ST_UPD_IR   : ST_PAUSE_IR;
         ST_PAUSE_IR: state_d = tms ? ST_EXIT2_IR : ST_PAUSE_IR;
         ST_EXIT2_IR: state_d = tms ? ST_UPD_IR   : ST_SHIFT_IR;
         ST_UPD_IR:   state_d = tms ? ST_SEL_DR   : ST_RTI;
         default:     state_d = ST_TLR;
      endcase
   end

   always_comb begin
      capture_dr = 1'b0;
      shift_dr   = 1'b0;
      update_dr  = 1'b0;
      capture_ir = 1'b0;
      shift_ir   = 1'b0;
      update_ir  = 1'b0;
      tlr        = 1'b0;
      case (state_q)
         ST_TLR:      tlr        = 1'b1;
         ST_CAP_DR:   capture_dr = 1'b1;
         ST_SHIFT_DR: shift_dr   = 1'b1;
         ST_UPD_DR:   update_dr  = 1'b1;
         ST_CAP_IR:   capture_ir = 1'b1;
         ST_SHIFT_IR: shift_ir   = 1'b1;
         ST_UPD_IR:   update_ir  = 1'b1;
         default:     ;
      endcase
   end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// TAP front end: instruction register, BYPASS/IDCODE/USERDATA data registers and TDO mux.
// IDCODE_VALUE bit 0 must stay 1 so a chain scan can tell IDCODE devices from bypassed ones.
module jtag_tap_ctrl
   import jtag_pkg::*;
#(
   parameter logic [31:0] IDCODE_VALUE = 32'h1000_0A5D,
   parameter int          USER_W       = 8
) (
   input  logic              TCK,
   input  logic              TRST,
   input  logic              TMS,
   input  logic              TDI,
   output logic              TDO,
   output logic              TDO_EN,
   input  logic [USER_W-1:0] CORE_LOGIC_DATA,
   output logic              SHIFTDR,
   output logic [USER_W-1:0] USER_DATA_OUT,
   output logic              USER_UPDATE,
   output logic [IR_W-1:0]   IR_OUT
);

   logic capture_dr, shift_dr, update_dr;
   logic capture_ir, shift_ir, update_ir;
   logic tlr;

   logic [IR_W-1:0]   ir;
   logic [IR_W-1:0]   ir_sr;
   logic [31:0]       idcode_sr;
   logic [USER_W-1:0] user_sr;
   logic              bypass_sr;
   logic [USER_W-1:0] user_data_out;
   logic              user_update;
   logic              tdo_bit;
   dr_sel_t           dr_sel;

   jtag_tap_fsm u_fsm (
      .clk_sys    (TCK),
      .rst        (TRST),
      .tms        (TMS),
      .capture_dr (capture_dr),
      .shift_dr   (shift_dr),
      .update_dr  (update_dr),
      .capture_ir (capture_ir),
      .shift_ir   (shift_ir),
      .update_ir  (update_ir),
      .tlr        (tlr)
   );

   assign dr_sel = decode_ir(ir);

   always_ff @(posedge TCK) begin
      if (TRST) begin
         ir    <= OP_IDCODE;
         ir_sr <= '0;
      end else begin
         if (tlr)            ir <= OP_IDCODE;
         else if (update_ir) ir <= ir_sr;

         if (capture_ir)     ir_sr <= IR_CAPTURE;
         else if (shift_ir)  ir_sr <= {TDI, ir_sr[IR_W-1:1]};
      end
   end

   // Only the register picked by the current IR moves; the others hold.
   always_ff @(posedge TCK) begin
      if (TRST) begin
         idcode_sr <= '0;
         user_sr   <= '0;
         bypass_sr <= 1'b0;
      end else if (capture_dr) begin
         case (dr_sel)
            DR_IDCODE: idcode_sr <= IDCODE_VALUE;
            DR_USER:   user_sr   <= CORE_LOGIC_DATA;
            default:   bypass_sr <= 1'b0;
         endcase
      end else if (shift_dr) begin
         case (dr_sel)
            DR_IDCODE: idcode_sr <= {TDI, idcode_sr[31:1]};
            DR_USER:   user_sr   <= {TDI, user_sr[USER_W-1:1]};
            default:   bypass_sr <= TDI;
         endcase
      end
   end

   always_ff @(posedge TCK) begin
      if (TRST) begin
         user_data_out <= '0;
         user_update   <= 1'b0;
      end else begin
         user_update <= 1'b0;
         if (update_dr && (dr_sel == DR_USER)) begin
            user_data_out <= user_sr;
            user_update   <= 1'b1;
         end
      end
   end

   always_comb begin
      tdo_bit = 1'b0;
      if (shift_ir) begin
         tdo_bit = ir_sr[0];
      end else if (shift_dr) begin
         case (dr_sel)
            DR_IDCODE: tdo_bit = idcode_sr[0];
            DR_USER:   tdo_bit = user_sr[0];
            default:   tdo_bit = bypass_sr;
         endcase
      end
   end

   assign TDO           = tdo_bit;
   assign TDO_EN        = shift_dr | shift_ir;
   assign SHIFTDR       = shift_dr;
   assign USER_DATA_OUT = user_data_out;
   assign USER_UPDATE   = user_update;
   assign IR_OUT        = ir;

endmodule

// File: doc/jtag_tap_ctrl.md
# jtag_tap_ctrl

IEEE 1149.1-style TAP controller and data-register front end that drives the JTAG shift protocol consumed by `core_logic`. It decodes TMS into the 16-state TAP machine and holds a 4-bit instruction register. It implements BYPASS, IDCODE and an 8-bit USERDATA register, which captures `CORE_LOGIC_DATA`, shifts it out on TDO and writes shifted-in data back to the core. It sits between the board JTAG pins and the core logic and generates the `SHIFTDR` strobe the core observes.

## Interface
- `IDCODE_VALUE`, 32'h1000_0A5D, device ID; bit 0 must be 1.
- `USER_W`, 8, USERDATA register width.
- `TCK  in  1`  sole clock; all state changes on rising edge.
- `TRST  in  1`  synchronous, active-high reset.
- `TMS  in  1`  TAP mode select, sampled on rising TCK.
- `TDI  in  1`  serial data in, sampled on rising TCK.
- `TDO  out  1`  serial data out; bit 0 of the active shift register while in Shift-DR/Shift-IR, else 0.
- `TDO_EN  out  1`  high in Shift-DR or Shift-IR.
- `CORE_LOGIC_DATA  in  USER_W`  parallel value captured in Capture-DR when IR=USERDATA.
- `SHIFTDR  out  1`  high while the state is Shift-DR, regardless of instruction.
- `USER_DATA_OUT  out  USER_W`  last value written via Update-DR under USERDATA.
- `USER_UPDATE  out  1`  one-cycle pulse when `USER_DATA_OUT` is loaded.
- `IR_OUT  out  4`  current instruction.

## Operation
- TAP FSM follows the standard 1149.1 graph, with 16 states from Test-Logic-Reset (TLR) through Update-IR. The next state is a function of the current state and TMS only.
- Opcodes: IDCODE=4'h1, USERDATA=4'h2, BYPASS=4'hF. All other codes select BYPASS.
- In TLR, IR is forced to IDCODE on every edge.
- Capture-IR edge: the IR shift register loads 4'b0101.
- Shift-IR edge: `{TDI, sr[3:1]}`.
- Update-IR edge: IR <= IR shift register.
- Capture-DR edge: the selected DR loads as follows.
  - IDCODE loads `IDCODE_VALUE`.
  - USERDATA loads `CORE_LOGIC_DATA`.
  - BYPASS loads 0.
- Shift-DR edge: the selected DR shifts right with TDI into the MSB. BYPASS is a single flop.
- Update-DR edge with IR=USERDATA: `USER_DATA_OUT` <= USERDATA shift register and `USER_UPDATE`=1 for the following cycle. With IDCODE or BYPASS, no side effect.
- Unselected DRs hold their value.
- Five consecutive TMS=1 edges from any state reach TLR.

## Timing
- All outputs except TDO/TDO_EN/SHIFTDR are registered. TDO, TDO_EN and SHIFTDR are decoded combinationally from the state and shift registers, so they are valid for the full cycle after the edge.
- A shift operation occurs on the same edge that leaves Shift-xR via TMS=1. A scan of N bits therefore needs N edges in Shift-xR, with TMS=1 on the Nth edge.
- Latency: TDO presents the captured bit 0 in the first cycle of Shift-DR. `USER_DATA_OUT` changes on the edge leaving Update-DR.
- Reset values (TRST=1 on an edge):
  - state=TLR, IR=IDCODE.
  - All shift registers 0.
  - `USER_DATA_OUT`=0, `USER_UPDATE`=0, TDO=0, TDO_EN=0, SHIFTDR=0.
- TRST mid-scan aborts the scan with no update.
- TRST has priority over TMS/TDI on the same edge.
- If an IR change occurs mid-DR path, it is impossible by construction, because IR updates only in Update-IR.

## Structure
- Package `jtag_pkg`:
  - TAP state enum (16 encodings).
  - Opcode constants.
  - IR width (4).
  - IR capture pattern 4'b0101.
- Sub-module `jtag_tap_fsm` holds the state register and next-state logic. It outputs decoded one-hot strobes: capture/shift/update for DR and IR, plus tlr.
- The top holds the IR, the DRs and the TDO mux.

## Test plan
- Reset with TRST, go to Shift-DR, scan 32 bits → TDO emits 32'h1000_0A5D LSB first, and `IR_OUT`=4'h1.
- IR scan shifting 4'h2 → TDO emits 1,0,1,0 and `IR_OUT`=4'h2 after Update-IR.
- USERDATA: `CORE_LOGIC_DATA`=8'hDD, DR scan with TDI=8'h3C → TDO emits 8'hDD LSB first. `USER_DATA_OUT`=8'h3C with a single `USER_UPDATE` pulse, and SHIFTDR high for exactly 8 cycles.
- IR=4'h7 (unknown) → 1-bit bypass: the first TDO bit is 0 and TDI appears on TDO one edge later.
- TMS=1 for 5 edges from Shift-DR → TLR, IR=IDCODE, `USER_DATA_OUT` unchanged.
- TRST asserted on the 4th bit of a USERDATA scan → everything at reset values and no `USER_UPDATE` pulse.
